alu_issue_ctrl: RTL and testbench

- Multi-cycle sequencer that drives the Mini-SRC 32-bit ALU: the producer side of the ALU's A/B/opcode/IncPC interface and the consumer of its C_out_HI/C_out_LO results.
- Accepts R-format instructions over a valid/ready handshake and increments PC through the ALU.
- Reads operands from the register file, issues the operation, waits for multi-cycle ops (mul/div), and writes the result to the register file or to HI/LO.

---
 rtl/alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Multi-cycle sequencer sitting in front of the Mini-SRC 32-bit ALU. It
//   accepts one R-format instruction at a time and runs it through a fixed
//   sequence of states:
//     IDLE  -> INCPC -> READ -> EXEC [-> WAIT] -> WB -> IDLE
//   INCPC borrows the ALU (IncPC select) to compute pc+1. READ covers the
//   register file's one-cycle read latency. EXEC/WAIT hold the ALU inputs
//   steady while the result settles. WB pulses the write strobes.
//
// Parameters
//   MULDIV_LAT  cycles the ALU inputs are held for mul/div (EXEC+WAIT), 1..15
//   PC_RESET    pc value after reset
//
// Ports
//   clock, clear                  clock / synchronous active-low reset
//   instr, instr_valid/ready      instruction intake handshake
//   rf_rd_addr_a/b, rf_rd_data_a/b register file read port (1-cycle latency)
//   alu_a, alu_b, alu_opcode,
//   alu_incpc, alu_hi, alu_lo     ALU operand/result interface
//   rf_wr_en/addr/data            register file write port
//   hilo_wr_en, hi_data, lo_data  HI/LO write port
//   pc                            program counter
//   done, illegal                 retire pulse / unsupported-opcode pulse
//
// Optional feature (macro ALU_ISSUE_FLAGS_EN)
//   Adds z_flag / n_flag outputs, refreshed on every write-back pulse and left
//   untouched when an illegal instruction retires.
//
// All outputs are registered. Strobes (rf_wr_en, hilo_wr_en, done, illegal)
// are high for exactly the WB cycle; data outputs hold between pulses.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rf_rd_addr_a,
    output logic [3:0]  rf_rd_addr_b,
    input  logic [31:0] rf_rd_data_a,
    input  logic [31:0] rf_rd_data_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    output logic        alu_incpc,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic        rf_wr_en,
    output logic [3:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        hilo_wr_en,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data,
    output logic [31:0] pc,
    output logic        done,
    output logic        illegal
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic        z_flag,
    output logic        n_flag
`endif
);

    // Instruction field layout (R-format)
    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [14:0] rsvd;
    } instr_t;

    // Fields the sequencer still needs after acceptance
    typedef struct packed {
        logic [4:0] op;
        logic [3:0] ra;
    } ir_t;

    typedef enum logic [2:0] {
        IDLE,
        INCPC,
        READ,
        EXEC,
        WAIT,
        WB
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // EXEC is the first of the MULDIV_LAT settle cycles; the counter covers
    // the remaining ones spent in WAIT.
    localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

    state_t     state;
    ir_t        ir;
    logic [3:0] cnt;
    instr_t     instr_f;
    logic       op_supported;
    logic       op_muldiv;

    assign instr_f = instr_t'(instr);

    // Reserved instruction bits are deliberately ignored.
    logic unused_rsvd;
    assign unused_rsvd = ^instr_f.rsvd;

    always_comb begin
        op_supported = 1'b0;
        op_muldiv    = 1'b0;
        case (ir.op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_NOT: op_supported = 1'b1;
            OP_MUL, OP_DIV: begin
                op_supported = 1'b1;
                op_muldiv    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state        <= IDLE;
            pc           <= PC_RESET;
            instr_ready  <= 1'b1;
            ir           <= '0;
            cnt          <= '0;
            rf_rd_addr_a <= '0;
            rf_rd_addr_b <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            alu_incpc    <= 1'b0;
            rf_wr_en     <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
            hilo_wr_en   <= 1'b0;
            hi_data      <= '0;
            lo_data      <= '0;
            done         <= 1'b0;
            illegal      <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            z_flag       <= 1'b0;
            n_flag       <= 1'b0;
`endif
        end else begin
            // Strobes default low so they only live for the WB cycle.
            rf_wr_en   <= 1'b0;
            hilo_wr_en <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;

            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir.op        <= instr_f.op;
                        ir.ra        <= instr_f.ra;
                        // Read addresses go out now so data is back by READ.
                        rf_rd_addr_a <= instr_f.rb;
                        rf_rd_addr_b <= instr_f.rc;
                        // Set up the ALU for pc+1 during INCPC.
                        alu_incpc    <= 1'b1;
                        alu_a        <= pc;
                        alu_b        <= '0;
                        instr_ready  <= 1'b0;
                        state        <= INCPC;
                    end
                end

                INCPC: begin
                    pc        <= alu_lo;
                    alu_incpc <= 1'b0;
                    state     <= READ;
                end

                READ: begin
                    // Operands land straight in the ALU input registers and
                    // stay put through EXEC/WAIT/WB.
                    alu_a      <= rf_rd_data_a;
                    alu_b      <= rf_rd_data_b;
                    alu_opcode <= ir.op;
                    state      <= EXEC;
                end

                EXEC: begin
                    if (!op_supported) begin
                        illegal <= 1'b1;
                        done    <= 1'b1;
                        state   <= WB;
                    end else if (op_muldiv) begin
                        cnt <= LAT_M1;
                        if (MULDIV_LAT > 1) begin
                            state <= WAIT;
                        end else begin
                            hi_data    <= alu_hi;
                            lo_data    <= alu_lo;
                            hilo_wr_en <= 1'b1;
                            done       <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                            z_flag     <= ({alu_hi, alu_lo} == 64'd0);
                            n_flag     <= alu_hi[31];
`endif
                            state      <= WB;
                        end
                    end else begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= ir.ra;
                        rf_wr_data <= alu_lo;
                        done       <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                        z_flag     <= (alu_lo == 32'd0);
                        n_flag     <= alu_lo[31];
`endif
                        state      <= WB;
                    end
                end

                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // cnt==1 means the counter reaches 0 at this edge: the
                    // ALU inputs have now been stable for MULDIV_LAT cycles.
                    if (cnt == 4'd1) begin
                        hi_data    <= alu_hi;
                        lo_data    <= alu_lo;
                        hilo_wr_en <= 1'b1;
                        done       <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                        z_flag     <= ({alu_hi, alu_lo} == 64'd0);
                        n_flag     <= alu_hi[31];
`endif
                        state      <= WB;
                    end
                end

                WB: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl with a behavioural register file
//   (one-cycle registered read) and a behavioural ALU. The ALU model only
//   produces a valid mul/div result once its inputs have been held for
//   MULDIV_LAT cycles, so an early capture shows up as a wrong HI/LO.
//   PC_RESET is 32'hFFFF_FFFF so the first INCPC exercises the wrap to 0.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int unsigned LAT = 4;
    localparam logic [31:0] PCR = 32'hFFFF_FFFF;

    logic        clock;
    logic        clear;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rf_rd_addr_a;
    logic [3:0]  rf_rd_addr_b;
    logic [31:0] rf_rd_data_a;
    logic [31:0] rf_rd_data_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic        alu_incpc;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        hilo_wr_en;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic [31:0] pc;
    logic        done;
    logic        illegal;

    alu_issue_ctrl #(
        .MULDIV_LAT (LAT),
        .PC_RESET   (PCR)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_incpc    (alu_incpc),
        .alu_hi       (alu_hi),
        .alu_lo       (alu_lo),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .hilo_wr_en   (hilo_wr_en),
        .hi_data      (hi_data),
        .lo_data      (lo_data),
        .pc           (pc),
        .done         (done),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: registered read, contents set by the bench.
    logic [31:0] rf [16];
    always @(posedge clock) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
    end

    // Track how many cycles the ALU inputs have been stable.
    logic [69:0] alu_in_cur;
    logic [69:0] alu_in_prev;
    int          held_r;
    int          held_now;
    assign alu_in_cur = {alu_a, alu_b, alu_opcode, alu_incpc};
    assign held_now   = (alu_in_cur === alu_in_prev) ? held_r + 1 : 1;
    always @(posedge clock) begin
        alu_in_prev <= alu_in_cur;
        held_r      <= held_now;
    end

    // ALU model
    logic [63:0] prod;
    always_comb begin
        alu_hi = 32'd0;
        alu_lo = 32'd0;
        prod   = 64'($signed(alu_a) * $signed(alu_b));
        if (alu_incpc) begin
            alu_lo = alu_a + 32'd1;
        end else begin
            case (alu_opcode)
                5'b00011: alu_lo = alu_a + alu_b;
                5'b00100: alu_lo = alu_a - alu_b;
                5'b01010: alu_lo = alu_a & alu_b;
                5'b01011: alu_lo = alu_a | alu_b;
                5'b10001: alu_lo = -alu_a;
                5'b10010: alu_lo = ~alu_a;
                5'b01111: begin
                    alu_hi = (held_now >= int'(LAT)) ? prod[63:32] : 32'hBAD0_BAD0;
                    alu_lo = (held_now >= int'(LAT)) ? prod[31:0]  : 32'hBAD1_BAD1;
                end
                5'b10000: begin
                    if (alu_b != 32'd0) begin
                        alu_hi = (held_now >= int'(LAT)) ? alu_a % alu_b : 32'hBAD2_BAD2;
                        alu_lo = (held_now >= int'(LAT)) ? alu_a / alu_b : 32'hBAD3_BAD3;
                    end
                end
                default: ;
            endcase
        end
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    // Called at cycle 1 after acceptance; steps until done (bounded) and
    // returns the cycle number in which done was seen. Also flags any
    // instr_ready or rf_wr_en seen before done.
    task automatic wait_done(output int lat, output logic saw_ready, output logic saw_wr);
        lat       = 1;
        saw_ready = instr_ready;
        saw_wr    = rf_wr_en | hilo_wr_en;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (!done) begin
                saw_ready = saw_ready | instr_ready;
                saw_wr    = saw_wr | rf_wr_en | hilo_wr_en;
            end
        end
    endtask

    int   lat;
    logic saw_ready;
    logic saw_wr;
    logic saw_any;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + i;
        rf[2] = 32'd5;
        rf[3] = 32'd7;
        clear       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        step();
        step();

        // ---- reset state
        chk("reset_ready", 64'(instr_ready), 64'd1);
        chk("reset_pc", 64'(pc), 64'(PCR));
        chk("reset_strobes", 64'({rf_wr_en, hilo_wr_en, done, illegal, alu_incpc}), 64'd0);
        chk("reset_data", {rf_wr_data, hi_data}, 64'd0);
        clear = 1'b1;
        step();

        // ---- add R1 = R2 + R3 (5 + 7), PC wraps FFFF_FFFF -> 0
        instr       = mk(5'b00011, 4'd1, 4'd2, 4'd3);
        instr_valid = 1'b1;
        step();                                  // acceptance edge
        chk("add_ready_drop", 64'(instr_ready), 64'd0);
        chk("add_incpc", {31'd0, alu_incpc, alu_a}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        // next instruction presented immediately and held
        instr = mk(5'b00100, 4'd6, 4'd2, 4'd3);
        step();
        chk("pc_wrap", 64'(pc), 64'd0);
        lat = 2;
        saw_ready = instr_ready;
        saw_wr = rf_wr_en;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (!done) begin
                saw_ready = saw_ready | instr_ready;
                saw_wr    = saw_wr | rf_wr_en;
            end
        end
        chk("add_latency", 64'(lat), 64'd4);
        chk("add_wb", {27'd0, rf_wr_en, hilo_wr_en, illegal, rf_wr_addr, rf_wr_data},
            {27'd0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd12});
        chk("add_busy_ready", 64'({saw_ready, saw_wr, instr_ready}), 64'd0);
        rf[2] = 32'd3;
        rf[3] = 32'd5;
        step();                                  // IDLE
        chk("idle_pulses", 64'({instr_ready, done, rf_wr_en}), 64'b100);
        chk("hold_wr_data", 64'(rf_wr_data), 64'd12);

        // ---- sub R6 = 3 - 5, accepted on this edge from held valid
        step();
        chk("sub_ready_drop", 64'(instr_ready), 64'd0);
        instr_valid = 1'b0;
        wait_done(lat, saw_ready, saw_wr);
        chk("sub_latency", 64'(lat), 64'd4);
        chk("sub_wb", {28'd0, rf_wr_en, rf_wr_addr, rf_wr_data},
            {28'd0, 1'b1, 4'd6, 32'hFFFF_FFFE});
        chk("sub_pc", 64'(pc), 64'd1);
        step();

        // ---- mul R4 * R5 = 0x4000_0001 * 4 -> HI=1, LO=4
        rf[4] = 32'h4000_0001;
        rf[5] = 32'd4;
        instr       = mk(5'b01111, 4'd7, 4'd4, 4'd5);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        wait_done(lat, saw_ready, saw_wr);
        chk("mul_latency", 64'(lat), 64'd7);
        chk("mul_hilo", {hi_data, lo_data}, {32'd1, 32'd4});
        chk("mul_strobes", 64'({hilo_wr_en, rf_wr_en, illegal, saw_wr}), 64'b1000);
        chk("mul_hold_rf", 64'(rf_wr_data), 64'hFFFF_FFFE);
        step();
        chk("mul_pulse_end", 64'({hilo_wr_en, done}), 64'd0);

        // ---- unsupported opcode 11111
        instr       = mk(5'b11111, 4'd8, 4'd2, 4'd3);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        wait_done(lat, saw_ready, saw_wr);
        chk("ill_latency", 64'(lat), 64'd4);
        chk("ill_strobes", 64'({done, illegal, rf_wr_en, hilo_wr_en, saw_wr}), 64'b11000);
        chk("ill_pc", 64'(pc), 64'd3);
        chk("ill_hold_hi", 64'(hi_data), 64'd1);
        step();

        // ---- div, reset asserted while in WAIT
        instr       = mk(5'b10000, 4'd9, 4'd4, 4'd5);
        instr_valid = 1'b1;
        step();                                  // cycle 1: INCPC
        instr_valid = 1'b0;
        step();                                  // 2: READ
        step();                                  // 3: EXEC
        step();                                  // 4: WAIT
        chk("div_in_wait", 64'({done, hilo_wr_en, instr_ready}), 64'd0);
        clear = 1'b0;
        step();                                  // reset edge
        chk("clr_state", {27'd0, instr_ready, hilo_wr_en, done, alu_incpc, illegal, pc},
            {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PCR});
        chk("clr_data", {hi_data, lo_data}, 64'd0);
        clear = 1'b1;
        saw_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            saw_any = saw_any | hilo_wr_en | done | rf_wr_en;
        end
        chk("clr_discard", 64'(saw_any), 64'd0);

        // ---- add after reset: R1 = 3 + 5, pc wraps again
        instr       = mk(5'b00011, 4'd1, 4'd2, 4'd3);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        wait_done(lat, saw_ready, saw_wr);
        chk("post_clr_add", {27'd0, rf_wr_en, rf_wr_addr, rf_wr_data},
            {27'd0, 1'b1, 4'd1, 32'd8});
        chk("post_clr_lat_pc", {32'(lat), pc}, {32'd4, 32'd0});
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
